// File: rtl/operand_pingpong_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_pingpong_bank_if
// Description : Write-stream and PE-read bundle for operand_pingpong_bank.
//               master = producer/consumer side, slave = the bank itself.
//   wr_valid/wr_ready/wr_data/wr_last : packed write beats (element 0 in LSBs)
//   rd_req/rd_addr -> rd_data/rd_valid/rd_oob : 1-cycle element reads
//   rd_release : consumer done with the read half
//   buf_ready/rd_len/wr_half/rd_half : bank status
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_pingpong_bank_if #(
    parameter int ELEM_W = 4,
    parameter int PACK   = 8,
    parameter int DEPTH  = 64
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [PACK*ELEM_W-1:0]     wr_data;
    logic                       wr_last;
    logic                       rd_req;
    logic [$clog2(DEPTH)-1:0]   rd_addr;
    logic [ELEM_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       rd_oob;
    logic                       rd_release;
    logic                       buf_ready;
    logic [$clog2(DEPTH):0]     rd_len;
    logic                       wr_half;
    logic                       rd_half;

    modport master (
        output wr_valid, wr_data, wr_last, rd_req, rd_addr, rd_release,
        input  wr_ready, rd_data, rd_valid, rd_oob, buf_ready, rd_len,
               wr_half, rd_half
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_req, rd_addr, rd_release,
        output wr_ready, rd_data, rd_valid, rd_oob, buf_ready, rd_len,
               wr_half, rd_half
    );
endinterface
`default_nettype wire

// File: rtl/operand_pingpong_bank.sv
`default_nettype none
// ============================================================================
// Module      : operand_pingpong_bank
// Description : Ping/pong operand bank. Packed beats are unpacked into the
//               write half; the PE reads single elements from the other half
//               with one-cycle latency. A half is FREE (writable) or FULL
//               (readable); closing a half toggles the write side, releasing
//               one toggles the read side.
// Ports       : clk, rst (sync, active high)
//               bus (slave modport of operand_pingpong_bank_if)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_pingpong_bank #(
    parameter int ELEM_W = 4,
    parameter int PACK   = 8,
    parameter int DEPTH  = 64
) (
    input  wire logic              clk,
    input  wire logic              rst,
    operand_pingpong_bank_if.slave bus
);
    localparam int C_AW = $clog2(DEPTH);
    localparam int C_LW = C_AW + 1;
    localparam logic [C_LW-1:0] C_PACK_L  = C_LW'(PACK);
    localparam logic [C_LW-1:0] C_DEPTH_L = C_LW'(DEPTH);
    localparam logic [C_AW-1:0] C_PACK_A  = C_AW'(PACK);

    typedef enum logic [0:0] {
        FREE = 1'b0,
        FULL = 1'b1
    } half_state_t;

    half_state_t       r_state [2];
    half_state_t       w_state_nxt [2];
    logic [C_LW-1:0]   r_len [2];
    logic [C_LW-1:0]   w_len_nxt [2];
    logic [C_AW-1:0]   r_wptr, w_wptr_nxt;
    logic              r_wr_sel, w_wr_sel_nxt;
    logic              r_rd_sel, w_rd_sel_nxt;

    logic [ELEM_W-1:0] r_mem [2*DEPTH];
    logic [ELEM_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_rd_oob;

    logic              w_wr_fire;
    logic              w_close;
    logic              w_rd_fire;
    logic              w_release;
    logic [C_LW-1:0]   w_wptr_end;

    assign bus.wr_ready  = (r_state[r_wr_sel] == FREE);
    assign bus.buf_ready = (r_state[r_rd_sel] == FULL);
    assign bus.rd_len    = bus.buf_ready ? r_len[r_rd_sel] : '0;
    assign bus.wr_half   = r_wr_sel;
    assign bus.rd_half   = r_rd_sel;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_oob    = r_rd_oob;

    assign w_wr_fire  = bus.wr_valid && bus.wr_ready;
    // One extra bit so the end-of-half compare sees DEPTH itself.
    assign w_wptr_end = {1'b0, r_wptr} + C_PACK_L;
    assign w_close    = w_wr_fire && ((w_wptr_end == C_DEPTH_L) || bus.wr_last);
    assign w_rd_fire  = bus.rd_req && bus.buf_ready;
    assign w_release  = bus.rd_release && bus.buf_ready;

    // Next-state logic. The closing half is FREE and the releasing half is
    // FULL, so the two indices never coincide and both updates can apply.
    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_wptr_nxt   = r_wptr;
        w_wr_sel_nxt = r_wr_sel;
        w_rd_sel_nxt = r_rd_sel;
        if (w_close) begin
            w_state_nxt[r_wr_sel] = FULL;
            w_len_nxt[r_wr_sel]   = w_wptr_end;
            w_wptr_nxt            = '0;
            w_wr_sel_nxt          = ~r_wr_sel;
        end else if (w_wr_fire) begin
            w_wptr_nxt = r_wptr + C_PACK_A;
        end
        if (w_release) begin
            w_state_nxt[r_rd_sel] = FREE;
            w_rd_sel_nxt          = ~r_rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= FREE;
            r_state[1] <= FREE;
            r_len[0]   <= '0;
            r_len[1]   <= '0;
            r_wptr     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_len    <= w_len_nxt;
            r_wptr   <= w_wptr_nxt;
            r_wr_sel <= w_wr_sel_nxt;
            r_rd_sel <= w_rd_sel_nxt;
        end
    end

    // Storage is not reset; a half's contents only become visible once the
    // half is FULL, and len bounds what may be read.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !rst) begin
            for (int i = 0; i < PACK; i++) begin
                r_mem[{r_wr_sel, r_wptr + C_AW'(i)}] <= bus.wr_data[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Read port: the request samples the pre-release half; rd_data holds
    // when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else if (w_rd_fire) begin
            r_rd_valid <= 1'b1;
            if ({1'b0, bus.rd_addr} < r_len[r_rd_sel]) begin
                r_rd_data <= r_mem[{r_rd_sel, bus.rd_addr}];
                r_rd_oob  <= 1'b0;
            end else begin
                r_rd_data <= '0;
                r_rd_oob  <= 1'b1;
            end
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_operand_pingpong_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_pingpong_bank
// Description : Directed + random stimulus for operand_pingpong_bank against
//               a FIFO-of-buffers reference model (at most two filled buffers
//               queued; the oldest one is the readable one).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_pingpong_bank;
    localparam int ELEM_W = 4;
    localparam int PACK   = 8;
    localparam int DEPTH  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_pingpong_bank_if #(.ELEM_W(ELEM_W), .PACK(PACK), .DEPTH(DEPTH)) bus ();

    operand_pingpong_bank #(.ELEM_W(ELEM_W), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: filled buffers concatenated in fill order, with
    // their lengths; cur is the buffer currently being filled.
    logic [3:0] fullq [$];
    int         lenq  [$];
    logic [3:0] cur   [$];
    int         fills;
    int         releases;
    logic [3:0] exp_data;
    logic       exp_valid;
    logic       exp_oob;

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("wr_ready",  32'(bus.wr_ready),  32'(lenq.size() < 2));
        chk("buf_ready", 32'(bus.buf_ready), 32'(lenq.size() > 0));
        chk("rd_len",    32'(bus.rd_len),    32'((lenq.size() > 0) ? lenq[0] : 0));
        chk("rd_valid",  32'(bus.rd_valid),  32'(exp_valid));
        chk("rd_oob",    32'(bus.rd_oob),    32'(exp_oob));
        chk("rd_data",   32'(bus.rd_data),   32'(exp_data));
        chk("wr_half",   32'(bus.wr_half),   32'(fills % 2));
        chk("rd_half",   32'(bus.rd_half),   32'(releases % 2));
    endtask

    // Advance one clock with the currently driven inputs, update the model
    // from the pre-edge view, then compare.
    task automatic cycle();
        bit acc, rdok, rel, last;
        logic [31:0] wd;
        int n, a;
        acc  = bus.wr_valid && (lenq.size() < 2);
        rdok = bus.rd_req && (lenq.size() > 0);
        rel  = bus.rd_release && (lenq.size() > 0);
        wd   = bus.wr_data;
        last = bus.wr_last;
        a    = int'(bus.rd_addr);
        if (rdok) begin
            exp_valid = 1'b1;
            if (a < lenq[0]) begin
                exp_data = fullq[a];
                exp_oob  = 1'b0;
            end else begin
                exp_data = 4'h0;
                exp_oob  = 1'b1;
            end
        end else begin
            exp_valid = 1'b0;
            exp_oob   = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rel) begin
            n = lenq.pop_front();
            repeat (n) void'(fullq.pop_front());
            releases++;
        end
        if (acc) begin
            for (int i = 0; i < PACK; i++) cur.push_back(wd[i*ELEM_W +: ELEM_W]);
            if (cur.size() == DEPTH || last) begin
                foreach (cur[i]) fullq.push_back(cur[i]);
                lenq.push_back(cur.size());
                cur.delete();
                fills++;
            end
        end
        check_outputs();
    endtask

    task automatic drive(bit wv, logic [31:0] wd, bit wl, bit rq, logic [5:0] ra, bit rl);
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.wr_last    = wl;
        bus.rd_req     = rq;
        bus.rd_addr    = ra;
        bus.rd_release = rl;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fullq.delete();
        lenq.delete();
        cur.delete();
        fills     = 0;
        releases  = 0;
        exp_data  = 4'h0;
        exp_valid = 1'b0;
        exp_oob   = 1'b0;
        check_outputs();
    endtask

    function automatic logic [31:0] rep8(int k);
        logic [3:0] n;
        n = 4'(k);
        return {8{n}};
    endfunction

    initial begin
        logic [31:0] d17;
        int addrs [5];
        addrs = '{0, 7, 8, 63, 31};

        do_reset();
        // Read and release while nothing is FULL: ignored.
        drive(0, 0, 0, 1, 6'd5, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Fill half 0 with beat k = {8{k}} and read back a/8.
        for (int k = 0; k < 8; k++) drive(1, rep8(k), 0, 0, 0, 0);
        foreach (addrs[i]) drive(0, 0, 0, 1, 6'(addrs[i]), 0);
        drive(0, 0, 0, 0, 0, 0);

        // Fill half 1 while reading half 0, then stall on the 17th beat.
        for (int k = 0; k < 8; k++)
            drive(1, $urandom, 0, 1, 6'($urandom_range(0, 63)), 0);
        d17 = $urandom;
        repeat (3) drive(1, d17, 0, 0, 0, 0);
        drive(1, d17, 0, 1, 6'd9, 1);
        drive(1, d17, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++) drive(1, $urandom, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Both halves FULL: read + release in the same cycle.
        drive(0, 0, 0, 1, 6'd17, 1);
        drive(0, 0, 0, 1, 6'd0, 0);
        drive(0, 0, 0, 1, 6'd63, 0);
        drive(0, 0, 0, 0, 0, 1);
        // Nothing readable now: rd_data must hold.
        drive(0, 0, 0, 1, 6'd3, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Early close on the third beat.
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, $urandom, (k == 2), 0, 0, 0);
        drive(0, 0, 0, 1, 6'd30, 0);
        drive(0, 0, 0, 1, 6'd23, 0);
        drive(0, 0, 0, 1, 6'd24, 0);
        drive(0, 0, 0, 1, 6'd0, 0);

        // Reset mid-fill, then a fresh fill reads back only new data.
        do_reset();
        for (int k = 0; k < 4; k++) drive(1, $urandom, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 8; k++) drive(1, $urandom, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) drive(0, 0, 0, 1, 6'($urandom_range(0, 63)), 0);

        // Random mixed traffic.
        for (int k = 0; k < 400; k++)
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 9) == 0));
        drive(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
